// File: rtl/iter_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in a final step.
module iter_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  // Handshake: start is sampled on a rising edge and accepted only while idle
  // with no done pulse showing; busy covers LOAD..DONE-state, then done pulses
  // for exactly one cycle while busy is low.
  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_b_raw;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_is_div;
  logic               w_dbz;

  always_comb begin
    w_is_div  = r_op[1];
    w_sa      = r_op[0] & r_a_raw[WIDTH-1];
    w_sb      = r_op[0] & r_b_raw[WIDTH-1];
    w_mag_a   = w_sa ? -r_a_raw : r_a_raw;
    w_mag_b   = w_sb ? -r_b_raw : r_b_raw;
    w_dbz     = w_is_div && (r_b_raw == '0);
    // Multiply step: conditional add into the upper half, then shift right.
    w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mcand} : '0);
    // Divide step: shift next dividend bit into the partial remainder.
    w_shift   = {r_acc, r_q[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_mcand};
    w_prod    = {r_acc, r_q};
    w_prod_s  = r_neg_q ? -w_prod : w_prod;
    w_quo     = r_neg_q ? -r_q : r_q;
    w_rem     = r_neg_r ? -r_acc : r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a_raw <= '0;
      r_b_raw <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_op    <= op;
            r_a_raw <= a;
            r_b_raw <= b;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mcand <= w_mag_b;
          r_q     <= w_mag_a;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_is_div) begin
            if (!w_diff[WIDTH]) begin
              r_acc <= w_diff[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= w_mul_sum[WIDTH:1];
            r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (w_is_div) begin
            if (w_dbz) begin
              r_lo <= '1;
              r_hi <= r_a_raw;
            end else begin
              r_lo <= w_quo;
              r_hi <= w_rem;
            end
          end else begin
            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_s[WIDTH-1:0];
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_dbz   <= w_dbz;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed bench for iter_muldiv_unit: latency, arithmetic results, divide by
// zero, handshake filtering, back-to-back spacing and asynchronous reset.
module tb_iter_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  iter_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start until accepted, then measures edges from the accepting edge
  // until done is seen (-1 on timeout) and the number of busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_n);
    bit acc;
    acc = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(posedge clk); #1;
      if (busy) acc = 1;
    end
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a  = $urandom;
    b  = $urandom;
    lat = -1;
    busy_n = 0;
    if (acc) begin
      for (int k = 0; k < 60; k++) begin
        if (done) begin
          lat = k;
          break;
        end
        if (busy) busy_n++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
    int lat, bn;
    run_op(o, x, y, lat, bn);
    chk({tag, "_lat"}, 64'(lat), 64'd35);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
  endtask

  initial begin
    int lat, bn, n, d;
    int dq[$];
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // MULU all-ones: latency and busy span
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    chk("mulu_lat", 64'(lat), 64'd35);
    chk("mulu_busy", 64'(bn), 64'd35);
    chk("mulu_busy_low", {63'd0, busy}, 64'd0);
    chk("mulu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    op_check("mul_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    op_check("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    op_check("div_neg", 2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    op_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    op_check("divu_z", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    op_check("mulu_34", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    op_check("div_z", 2'b11, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF, 1'b1);

    // Second start during an operation is ignored
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    chk("hs_busy", {63'd0, busy}, 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 32'd5; b = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("hs_ndone", 64'(n), 64'd1);
    chk("hs_res", {hi, lo}, 64'd6);

    // start held high: consecutive done pulses
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done) dq.push_back(k);
    end
    @(negedge clk) start = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    d = (dq.size() >= 2) ? dq[1] - dq[0] : -1;
    chk("b2b_npulse", 64'(dq.size()), 64'd2);
    chk("b2b_gap", 64'(d), 64'd37);
    chk("b2b_res", {hi, lo}, 64'd6);

    // Asynchronous reset in the middle of RUN
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("arst_nodone", 64'(n), 64'd0);

    op_check("post_rst", 2'b01, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
